// File: rtl/time_countdown_pkg.sv
// Shared time definitions: countdown states, BCD digit maxima, clamp helper.
// No logic of its own; consumed by the countdown top and its digit decrementers.
// Not applicable: no handshakes live here.
package time_countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   // Largest legal value of a units digit and of a tens-of-minutes/seconds digit
   localparam logic [3:0] UNITS_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX  = 4'd5;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_v);
      return (d > max_v) ? max_v : d;
   endfunction

endpackage

// File: rtl/time_countdown_bcd_digit_down.sv
// Single BCD digit decrementer with borrow chain and wrap to MODULUS-1.
// Latency: purely combinational.
// No backpressure: borrow_i is the only qualifier.
module bcd_digit_down #(
   parameter int MODULUS = 10
) (
   input  logic [3:0] digit_i,
   input  logic       borrow_i,
   output logic [3:0] digit_o,
   output logic       borrow_o
);

   localparam logic [3:0] TOP_DIGIT = 4'(MODULUS - 1);

   // Subtract the incoming borrow; a zero digit wraps and passes the borrow on
   always_comb begin
      borrow_o = borrow_i && (digit_i == 4'd0);
      digit_o  = digit_i;
      if (borrow_i) begin
         digit_o = (digit_i == 4'd0) ? TOP_DIGIT : (digit_i - 4'd1);
      end
   end

endmodule

// File: rtl/time_countdown.sv
// HH:MM:SS BCD countdown timer with load/start/pause control and expiry pulse.
// Latency: a tick or control input is reflected on the registered outputs one cycle later.
// No backpressure: ticks arriving outside RUN, or alongside start/pause, are dropped.
module time_countdown
   import time_countdown_pkg::*;
#(
   parameter int DIGIT_CLAMP = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic       tick,
   input  logic [3:0] pHour10,
   input  logic [3:0] pHour1,
   input  logic [3:0] pMinute10,
   input  logic [3:0] pMinute1,
   input  logic [3:0] pSecond10,
   input  logic [3:0] pSecond1,
   output logic [3:0] Hour10,
   output logic [3:0] Hour1,
   output logic [3:0] Minute10,
   output logic [3:0] Minute1,
   output logic [3:0] Second10,
   output logic [3:0] Second1,
   output logic       running,
   output logic       expired,
   output logic       done
);

   // Digit index 0 is Second1, index 5 is Hour10
   logic [5:0][3:0] cnt_q;
   logic [5:0][3:0] cnt_dec;
   logic [5:0][3:0] preset_raw;
   logic [5:0][3:0] preset_lim;
   logic [6:0]      borrow;
   logic            cnt_zero;
   logic            dec_zero;
   logic            unused_top_borrow;

   state_t state_q;
   logic   running_q;
   logic   expired_q;
   logic   done_q;

   assign preset_raw = {pHour10, pHour1, pMinute10, pMinute1, pSecond10, pSecond1};

   // A tick always removes exactly one second from Second1
   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_digit
         localparam bit         IS_TENS  = (gi == 1) || (gi == 3);
         localparam logic [3:0] DIGIT_MX = IS_TENS ? TENS_MAX : UNITS_MAX;

         bcd_digit_down #(
            .MODULUS (IS_TENS ? 6 : 10)
         ) u_digit (
            .digit_i  (cnt_q[gi]),
            .borrow_i (borrow[gi]),
            .digit_o  (cnt_dec[gi]),
            .borrow_o (borrow[gi+1])
         );

         assign preset_lim[gi] = (DIGIT_CLAMP != 0) ? clamp_digit(preset_raw[gi], DIGIT_MX)
                                                    : preset_raw[gi];
      end
   endgenerate

   // The chain never underflows: RUN is only held with a nonzero count
   assign unused_top_borrow = borrow[6];

   assign cnt_zero = (cnt_q == '0);
   assign dec_zero = (cnt_dec == '0);

   // Control FSM and count register; priority rst > load > pause > start > tick
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            cnt_q     <= preset_lim;
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (pause) begin
                     state_q   <= ST_PAUSE;
                     running_q <= 1'b0;
                  end else if (!start && tick) begin
                     cnt_q <= cnt_dec;
                     if (dec_zero) begin
                        state_q   <= ST_EXPIRED;
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                        done_q    <= 1'b1;
                     end
                  end
               end
               ST_IDLE, ST_PAUSE: begin
                  if (start) begin
                     if (cnt_zero) begin
                        state_q   <= ST_EXPIRED;
                        expired_q <= 1'b1;
                        done_q    <= 1'b1;
                     end else begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  // EXPIRED holds 00:00:00 until load or rst
               end
            endcase
         end
      end
   end

   assign {Hour10, Hour1, Minute10, Minute1, Second10, Second1} = cnt_q;
   assign running = running_q;
   assign expired = expired_q;
   assign done    = done_q;

endmodule

// File: tb/tb_time_countdown.sv
// Self-checking bench for time_countdown: directed scenarios then random control.
// Reference keeps the count as total seconds and the state as a small integer.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_time_countdown;

   logic        clk = 1'b0;
   logic        rst, load, start, pause, tick;
   logic [23:0] pre;
   logic [3:0]  Hour10, Hour1, Minute10, Minute1, Second10, Second1;
   logic        running, expired, done;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: 0 idle, 1 run, 2 pause, 3 expired
   int m_secs = 0;
   int m_st   = 0;
   bit m_done = 1'b0;

   always #5 clk = ~clk;

   time_countdown #(.DIGIT_CLAMP(1)) dut (
      .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause), .tick(tick),
      .pHour10(pre[23:20]), .pHour1(pre[19:16]), .pMinute10(pre[15:12]),
      .pMinute1(pre[11:8]), .pSecond10(pre[7:4]), .pSecond1(pre[3:0]),
      .Hour10(Hour10), .Hour1(Hour1), .Minute10(Minute10), .Minute1(Minute1),
      .Second10(Second10), .Second1(Second1),
      .running(running), .expired(expired), .done(done)
   );

   function automatic int lim(input logic [3:0] d, input int mx);
      return (int'(d) > mx) ? mx : int'(d);
   endfunction

   function automatic int preset_secs(input logic [23:0] p);
      int h, m, s;
      h = lim(p[23:20], 9) * 10 + lim(p[19:16], 9);
      m = lim(p[15:12], 5) * 10 + lim(p[11:8], 9);
      s = lim(p[7:4], 5) * 10 + lim(p[3:0], 9);
      return (h * 60 + m) * 60 + s;
   endfunction

   function automatic logic [23:0] to_bcd(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"},   {Hour10, Hour1, Minute10, Minute1, Second10, Second1}, to_bcd(m_secs));
      chk({tag, ".running"}, 24'(running), 24'(m_st == 1));
      chk({tag, ".expired"}, 24'(expired), 24'(m_st == 3));
      chk({tag, ".done"},    24'(done),    24'(m_done));
   endtask

   task automatic model(input bit r, input bit ld, input bit sa, input bit pa,
                        input bit tk, input logic [23:0] p);
      m_done = 1'b0;
      if (r) begin
         m_st = 0; m_secs = 0;
      end else if (ld) begin
         m_st = 0; m_secs = preset_secs(p);
      end else if (m_st == 1) begin
         if (pa) m_st = 2;
         else if (!sa && tk) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin m_st = 3; m_done = 1'b1; end
         end
      end else if (m_st == 0 || m_st == 2) begin
         if (sa) begin
            if (m_secs == 0) begin m_st = 3; m_done = 1'b1; end
            else m_st = 1;
         end
      end
   endtask

   task automatic step(input string tag, input bit r, input bit ld, input bit sa,
                       input bit pa, input bit tk, input logic [23:0] p);
      @(negedge clk);
      rst = r; load = ld; start = sa; pause = pa; tick = tk; pre = p;
      model(r, ld, sa, pa, tk, p);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic cnt_is(input string tag, input logic [23:0] exp);
      chk(tag, {Hour10, Hour1, Minute10, Minute1, Second10, Second1}, exp);
   endtask

   initial begin
      logic [23:0] rp;
      rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0; pre = '0;

      // Reset state
      step("rst0", 1, 0, 0, 0, 0, 24'h0);
      step("rst1", 1, 0, 0, 0, 0, 24'h0);
      cnt_is("reset_zero", 24'h000000);
      step("idle_tick", 0, 0, 0, 0, 1, 24'h0);

      // Three-second countdown to expiry
      step("a_load",  0, 1, 0, 0, 0, 24'h000003);
      step("a_start", 0, 0, 1, 0, 0, 24'h0);
      step("a_t1",    0, 0, 0, 0, 1, 24'h0);
      cnt_is("a_02", 24'h000002);
      step("a_gap",   0, 0, 0, 0, 0, 24'h0);
      step("a_t2",    0, 0, 0, 0, 1, 24'h0);
      step("a_t3",    0, 0, 0, 0, 1, 24'h0);
      chk("a_done_pulse", 24'(done), 24'h1);
      step("a_hold",  0, 0, 0, 0, 1, 24'h0);
      chk("a_done_once", 24'(done), 24'h0);
      chk("a_expired", 24'(expired), 24'h1);

      // Full borrow chain from the hours digit
      step("b_load",  0, 1, 0, 0, 0, 24'h010000);
      step("b_start", 0, 0, 1, 0, 0, 24'h0);
      step("b_tick",  0, 0, 0, 0, 1, 24'h0);
      cnt_is("b_005959", 24'h005959);

      // Pause with a coincident tick, then resume; start with tick drops the tick
      step("c_load",  0, 1, 0, 0, 0, 24'h001000);
      step("c_start", 0, 0, 1, 0, 0, 24'h0);
      step("c_ptick", 0, 0, 0, 1, 1, 24'h0);
      cnt_is("c_held", 24'h001000);
      step("c_stick", 0, 0, 1, 0, 1, 24'h0);
      step("c_tick",  0, 0, 0, 0, 1, 24'h0);
      cnt_is("c_000959", 24'h000959);

      // Zero preset expires straight away
      step("d_load",  0, 1, 0, 0, 0, 24'h000000);
      step("d_start", 0, 0, 1, 0, 0, 24'h0);
      chk("d_done", 24'(done), 24'h1);
      step("d_t1",    0, 0, 0, 0, 1, 24'h0);
      step("d_t2",    0, 0, 1, 0, 1, 24'h0);

      // Out-of-range preset digits clamp
      step("e_load",  0, 1, 0, 0, 0, 24'h0F7999);
      cnt_is("e_clamp", 24'h095959);

      // Reset mid-run, then load beating start mid-run
      step("f_load",  0, 1, 0, 0, 0, 24'h000502);
      step("f_start", 0, 0, 1, 0, 0, 24'h0);
      step("f_t1",    0, 0, 0, 0, 1, 24'h0);
      step("f_t2",    0, 0, 0, 0, 1, 24'h0);
      cnt_is("f_000500", 24'h000500);
      step("f_rst",   1, 0, 0, 0, 1, 24'h0);
      step("f_load2", 0, 1, 0, 0, 0, 24'h001234);
      step("f_start2",0, 0, 1, 0, 0, 24'h0);
      step("f_t3",    0, 0, 0, 0, 1, 24'h0);
      step("f_ldst",  0, 1, 1, 0, 1, 24'h002000);
      cnt_is("f_newpre", 24'h002000);

      // Random control traffic with small presets so expiry happens often
      for (int n = 0; n < 1500; n++) begin
         rp = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
         if ($urandom_range(0, 3) != 0) rp[23:8] = 16'h0;
         if ($urandom_range(0, 1) != 0) rp[7:4] = 4'h0;
         step("rnd",
              ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 1) == 0),
              rp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
